// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Optional `MD_CANCEL_EN adds a Cancel input that aborts an in-flight operation.
module md_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  Op,
  input  logic        Start,
`ifdef MD_CANCEL_EN
  input  logic        Cancel,
`endif
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, r_q, r_d, dq_q, dq_d, hi_q, hi_d, lo_q, lo_d;
  logic sgn_q, sgn_d, cancel, ge;
  logic [63:0] prod;
  logic [32:0] rs;
  logic [31:0] dvm, nr, nq, qf, rf;
`ifdef MD_CANCEL_EN
  assign cancel = Cancel;
`else
  assign cancel = 1'b0;
`endif
  // sign-extending only for signed ops lets one unsigned multiplier serve both
  assign prod = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};
  assign dvm  = (sgn_q & b_q[31]) ? -b_q : b_q;
  assign rs   = {r_q, dq_q[31]};
  assign ge   = rs >= {1'b0, dvm};
  assign nr   = ge ? 32'(rs - {1'b0, dvm}) : rs[31:0];
  assign nq   = {dq_q[30:0], ge};
  assign qf   = (sgn_q & (a_q[31] ^ b_q[31])) ? -nq : nq;
  assign rf   = (sgn_q & a_q[31]) ? -nr : nr;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    r_d     = r_q;
    dq_d    = dq_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: if (Start && !cancel) begin
        if (!Op[2]) begin
          a_d     = A;
          b_d     = B;
          sgn_d   = ~Op[0];
          r_d     = '0;
          dq_d    = (~Op[0] & A[31]) ? -A : A;
          state_d = Op[1] ? DIV : MUL;
          cnt_d   = Op[1] ? 5'(DIV_CYCLES - 1) : 5'(MUL_CYCLES - 1);
        end else if (!Op[1]) begin
          hi_d = Op[0] ? hi_q : A;
          lo_d = Op[0] ? A : lo_q;
        end
      end
      MUL: begin
        cnt_d = cnt_q - 5'd1;
        if (cancel) state_d = IDLE;
        else if (cnt_q == 5'd0) begin
          {hi_d, lo_d} = prod;
          state_d      = IDLE;
        end
      end
      DIV: begin
        cnt_d = cnt_q - 5'd1;
        r_d   = nr;
        dq_d  = nq;
        if (cancel) state_d = IDLE;
        else if (cnt_q == 5'd0) begin
          hi_d    = (b_q == 32'd0) ? a_q : rf;
          lo_d    = (b_q == 32'd0) ? 32'hFFFF_FFFF : qf;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      r_q     <= '0;
      dq_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      r_q     <= r_d;
      dq_q    <= dq_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign Busy = state_q != IDLE;
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed plus randomized checks of md_unit with a {HI,LO} scoreboard.
module tb_md_unit;
  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3, MTHI = 3'd4, MTLO = 3'd5;
  logic clk = 1'b0, rst_n = 1'b1, Start = 1'b0, Cancel = 1'b0, Busy;
  logic [31:0] A = '0, B = '0, HI, LO;
  logic [2:0] Op = '0;
  logic [63:0] sbq[$];
  int n_assert = 0, n_fail = 0;
  md_unit dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Op(Op), .Start(Start),
`ifdef MD_CANCEL_EN
    .Cancel(Cancel),
`endif
    .Busy(Busy), .HI(HI), .LO(LO)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MULT:  return 64'(sa * sb);
      MULTU: return {32'd0, a} * {32'd0, b};
      DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    endcase
  endfunction
  // Called at a negedge; returns at the first negedge where Busy is low again.
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input int cyc, input int poke_cyc, input logic [2:0] poke_op);
    logic [63:0] prev;
    int n;
    sbq.push_back(exp);
    prev = {HI, LO};
    Op = op; A = a; B = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; A = $urandom; B = $urandom;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      check("hold", {HI, LO}, prev);
      Start = (n == poke_cyc); Op = poke_op; A = 32'd1; B = 32'd1;
      @(negedge clk);
    end
    Start = 1'b0;
    check("busy_cycles", 64'(n), 64'(cyc));
    check("result", {HI, LO}, sbq.pop_front());
  endtask
  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    #1 rst_n = 1'b0;
    #20;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 5, 0, MULT);
    run(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 2, MULTU);
    run(DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32, 5, MTLO);
    run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 32, 32, MULT);
    run(DIVU, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 32, 0, MULT);
    run(DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 32, 0, MULT);
    run(MTHI, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'd14}, 0, 0, MULT);
    run(MTLO, 32'h9ABC_DEF0, 32'd0, 64'h1234_5678_9ABC_DEF0, 0, 0, MULT);
    run(DIV, 32'd7, 32'hFFFF_FFFE, model(DIV, 32'd7, 32'hFFFF_FFFE), 32, 0, MULT);
    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 2 == 1) ? 32'($urandom_range(1, 20)) : $urandom;
      run(op, a, b, model(op, a, b), op[1] ? 32 : 5, 0, MULT);
    end
    Op = DIV; A = 32'd1000; B = 32'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(Busy), 64'd0);
    check("async_rst_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(MULT, 32'd6, 32'd7, 64'd42, 5, 0, MULT);
`ifdef MD_CANCEL_EN
    Op = MULT; A = 32'd3; B = 32'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    Cancel = 1'b1;
    @(negedge clk);
    check("cancel_busy", 64'(Busy), 64'd0);
    check("cancel_hilo", {HI, LO}, 64'd42);
    Op = MTHI; A = 32'hDEAD_BEEF; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; Cancel = 1'b0;
    check("cancel_idle_hilo", {HI, LO}, 64'd42);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
